// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if
//   Bundles the requester side and the selector side of the round-robin
//   arbiter for the 4-input selector datapath.
//   req        : request per requester (bit i = requester i)
//   a, b, c, d : data words of requesters 0..3
//   gnt        : one-hot grant, zero when no owner
//   sel        : selector code of the current owner, 0 when no owner
//   mux_en_n   : active-low datapath enable, low only while an owner exists
//   out        : registered selected word, 0 when not valid
//   out_valid  : out holds owner data
//   master = requester/environment side, slave = arbiter side.
interface mux_rr_arbiter_if #(
    parameter int unsigned WIDTH = 4
);
    logic [3:0]       req;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic             mux_en_n;
    logic [WIDTH-1:0] out;
    logic             out_valid;

    modport master (
        output req, a, b, c, d,
        input  gnt, sel, mux_en_n, out, out_valid
    );

    modport slave (
        input  req, a, b, c, d,
        output gnt, sel, mux_en_n, out, out_valid
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter/sequencer for a 4-input selector. Grants one requester
//   at a time, bounds tenure to MAX_HOLD cycles while others wait, inserts a
//   one-cycle dead gap between owners, and registers the selected word.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux_rr_arbiter_if.slave (req/data in, gnt/sel/mux_en_n/out/out_valid out)
module mux_rr_arbiter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_rr_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       last_q, last_d;
    logic [7:0]       hold_q, hold_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             en_n_q, en_n_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;

    logic [1:0]       pick;
    logic [1:0]       idx;
    logic             at_max;

    assign at_max = (hold_q == 8'(MAX_HOLD));

    // Walk from lowest to highest priority so the last hit is the winner:
    // i=0 examines last_owner itself, i=3 examines last_owner+1.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = last_q + 2'(4 - i);
            if (bus.req[idx]) begin
                pick = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        en_n_d  = en_n_q;
        case (state_q)
            IDLE, GAP: begin
                if (|bus.req) begin
                    state_d = OWN;
                    owner_d = pick;
                    gnt_d   = 4'b0001 << pick;
                    sel_d   = pick;
                    en_n_d  = 1'b0;
                    hold_d  = 8'd1;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    sel_d   = '0;
                    en_n_d  = 1'b1;
                    hold_d  = '0;
                end
            end
            OWN: begin
                if (!bus.req[owner_q] || (at_max && |(bus.req & ~gnt_q))) begin
                    state_d = GAP;
                    gnt_d   = '0;
                    sel_d   = '0;
                    en_n_d  = 1'b1;
                    last_d  = owner_q;
                    hold_d  = '0;
                end else if (at_max) begin
                    hold_d = 8'd1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                sel_d   = '0;
                en_n_d  = 1'b1;
                hold_d  = '0;
            end
        endcase
    end

    // Data path uses the registered sel/enable, giving one cycle grant-to-data.
    always_comb begin
        out_d   = '0;
        valid_d = ~en_n_q;
        if (!en_n_q) begin
            case (sel_q)
                2'd0:    out_d = bus.a;
                2'd1:    out_d = bus.b;
                2'd2:    out_d = bus.c;
                default: out_d = bus.d;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= 2'd3;
            hold_q  <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            en_n_q  <= 1'b1;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            en_n_q  <= en_n_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.mux_en_n  = en_n_q;
    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter
//   Scoreboard bench for mux_rr_arbiter: a behavioural reference predicts the
//   outputs after each edge, directed checks cover the listed scenarios.
module tb_mux_rr_arbiter;
    localparam int unsigned W  = 4;
    localparam int unsigned MH = 8;

    logic clk;
    logic rst_n;

    mux_rr_arbiter_if #(.WIDTH(W)) bif ();

    mux_rr_arbiter #(
        .WIDTH    (W),
        .MAX_HOLD (MH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   gnt;
        logic [1:0]   sel;
        logic         en_n;
        logic [W-1:0] out;
        logic         valid;
    } exp_t;

    exp_t sbq[$];

    int checks   = 0;
    int failures = 0;

    // Reference state
    bit         m_owning;
    int         m_owner;
    int         m_last;
    int         m_cnt;
    logic [1:0] m_sel;
    logic       m_en_n;
    logic [W-1:0] m_out;
    logic       m_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owning = 0;
        m_owner  = 0;
        m_last   = 3;
        m_cnt    = 0;
        m_sel    = 0;
        m_en_n   = 1;
        m_out    = 0;
        m_valid  = 0;
    endtask

    function automatic logic [W-1:0] word_of(input int s);
        case (s)
            0:       return bif.a;
            1:       return bif.b;
            2:       return bif.c;
            default: return bif.d;
        endcase
    endfunction

    // Predict register contents after the coming edge from current inputs.
    task automatic model_edge();
        int others;
        m_valid = !m_en_n;
        m_out   = m_en_n ? '0 : word_of(int'(m_sel));
        if (m_owning) begin
            others = int'(bif.req) & ~(1 << m_owner) & 15;
            if (!bif.req[m_owner] || (m_cnt == MH && others != 0)) begin
                m_owning = 0;
                m_last   = m_owner;
                m_cnt    = 0;
            end else if (m_cnt == MH) begin
                m_cnt = 1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end else if (bif.req != 0) begin
            for (int k = 4; k >= 1; k--) begin
                if (bif.req[(m_last + k) % 4]) m_owner = (m_last + k) % 4;
            end
            m_owning = 1;
            m_cnt    = 1;
        end
        m_sel  = m_owning ? 2'(m_owner) : 2'd0;
        m_en_n = !m_owning;
    endtask

    task automatic step();
        exp_t e;
        exp_t r;
        model_edge();
        e.gnt   = m_owning ? 4'(1 << m_owner) : 4'd0;
        e.sel   = m_sel;
        e.en_n  = m_en_n;
        e.out   = m_out;
        e.valid = m_valid;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        r = sbq.pop_front();
        check("gnt", bif.gnt, r.gnt);
        check("sel", bif.sel, r.sel);
        check("mux_en_n", bif.mux_en_n, r.en_n);
        check("out", bif.out, r.out);
        check("out_valid", bif.out_valid, r.valid);
        check("onehot", $onehot0(bif.gnt), 1);
        check("en_vs_gnt", bif.mux_en_n, bif.gnt == 4'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        sbq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int        order[$];
    logic [3:0] prev_gnt;
    logic [3:0] exp_g;

    initial begin
        rst_n   = 1'b0;
        bif.req = 4'b1111;
        bif.a   = 4'h1;
        bif.b   = 4'h2;
        bif.c   = 4'h3;
        bif.d   = 4'h4;
        model_reset();

        // Reset values while requests are pending
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", bif.gnt, 4'b0000);
        check("rst_sel", bif.sel, 2'd0);
        check("rst_en_n", bif.mux_en_n, 1'b1);
        check("rst_out", bif.out, 4'h0);
        check("rst_valid", bif.out_valid, 1'b0);
        rst_n = 1'b1;

        // Rotation with all requesting
        prev_gnt = 4'b0000;
        for (int i = 0; i < 42; i++) begin
            step();
            if (i == 0) check("first_gnt", bif.gnt, 4'b0001);
            if (bif.gnt != 4'b0000 && prev_gnt == 4'b0000) order.push_back(int'(bif.sel));
            prev_gnt = bif.gnt;
        end
        check("rot_count", order.size() >= 5, 1);
        if (order.size() >= 5) begin
            for (int i = 0; i < 5; i++) check("rot_order", order[i], i % 4);
        end

        // Contention between 0 and 2
        do_reset();
        bif.req = 4'b0101;
        for (int i = 0; i < 19; i++) begin
            step();
            if (i < 8)       exp_g = 4'b0001;
            else if (i == 8) exp_g = 4'b0000;
            else if (i < 17) exp_g = 4'b0100;
            else if (i == 17) exp_g = 4'b0000;
            else             exp_g = 4'b0001;
            check("contend_gnt", bif.gnt, exp_g);
        end

        // Single requester keeps the grant without gaps
        do_reset();
        bif.req = 4'b0100;
        bif.c   = 4'hA;
        for (int i = 0; i < 20; i++) begin
            step();
            check("single_gnt", bif.gnt, 4'b0100);
            check("single_sel", bif.sel, 2'd2);
            if (i >= 1) begin
                check("single_out", bif.out, 4'hA);
                check("single_valid", bif.out_valid, 1'b1);
            end
        end

        // Early release by owner 1 while 3 waits
        do_reset();
        bif.req = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            step();
            check("early_own", bif.gnt, 4'b0010);
        end
        bif.req = 4'b1000;
        step();
        check("early_gap", bif.gnt, 4'b0000);
        step();
        check("early_next", bif.gnt, 4'b1000);
        step();
        check("early_valid_drop", bif.out_valid, 1'b1);

        // Random traffic against the reference
        do_reset();
        for (int n = 0; n < 300; n++) begin
            if (n % 13 == 0) bif.req = 4'($urandom_range(0, 15));
            bif.a = 4'($urandom);
            bif.b = 4'($urandom);
            bif.c = 4'($urandom);
            bif.d = 4'($urandom);
            step();
        end

        // Asynchronous reset in the middle of owner 2's tenure
        do_reset();
        bif.req = 4'b0100;
        step();
        step();
        check("pre_async_gnt", bif.gnt, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_gnt", bif.gnt, 4'b0000);
        check("async_en_n", bif.mux_en_n, 1'b1);
        check("async_out", bif.out, 4'h0);
        check("async_valid", bif.out_valid, 1'b0);
        model_reset();
        sbq.delete();
        bif.req = 4'b0110;
        #2;
        rst_n = 1'b1;
        step();
        check("post_async_gnt", bif.gnt, 4'b0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer for the 4-input, 4-bit selector datapath. Four requesters each present a data word and a request; the block grants one at a time and drives the selector's `sel` and active-low enable. It also registers the selected word with a valid flag. Grant hold time is bounded so no requester can starve the others, and a one-cycle dead gap separates successive owners.

## Interface
Parameters:
- `WIDTH`, 4, data word width of each requester and of `out`.
- `MAX_HOLD`, 8, maximum consecutive owned cycles while another requester waits; legal range 2..255.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  4  request per requester; bit i belongs to requester i.
- `a`, `b`, `c`, `d`  in  WIDTH each  data of requesters 0, 1, 2, 3.
- `gnt`  out  4  one-hot grant; all zero when no owner.
- `sel`  out  2  selector code of the current owner; 0 when no owner.
- `mux_en_n`  out  1  active-low datapath enable; 0 only while an owner exists.
- `out`  out  WIDTH  registered selected data; 0 when not valid.
- `out_valid`  out  1  `out` holds owner data.

## Operation
- Internal state: FSM {IDLE, OWN, GAP}, 2-bit `owner`, 2-bit `last_owner`, 8-bit `hold_cnt`.
- All outputs are registered.
- Reset values (async, while `rst_n`=0):
  - state=IDLE, `gnt`=0, `sel`=0, `mux_en_n`=1, `out`=0, `out_valid`=0, `hold_cnt`=0.
  - `last_owner`=3, so requester 0 has top priority after reset.
- Pick rule: scan `req` starting at (`last_owner`+1) mod 4 and wrapping; the first set bit wins. 2-bit index arithmetic wraps naturally.
- IDLE:
  - `gnt`=0, `mux_en_n`=1.
  - If `req`≠0, pick a winner; next state OWN with `owner`=winner, `gnt`=1<<winner, `sel`=winner, `mux_en_n`=0, `hold_cnt`=1.
- OWN, evaluated each edge with current `req`:
  - If `req[owner]`=0: release.
  - Else if `hold_cnt`=MAX_HOLD and (`req` & ~`gnt`)≠0: release.
  - Else if `hold_cnt`=MAX_HOLD with no other requester: stay, `hold_cnt`=1.
  - Else: stay, `hold_cnt`+1.
  - Release: next state GAP; `gnt`=0, `sel`=0, `mux_en_n`=1, `last_owner`=`owner`, `hold_cnt`=0.
- GAP:
  - Exactly one cycle with no owner.
  - If `req`≠0, pick (using the updated `last_owner`) and enter OWN as from IDLE; else go to IDLE.
  - The just-released requester may win again only if it is the sole requester.
- Data path, every edge:
  - `out` ← word selected by `sel` if `mux_en_n`=0, else 0.
  - `out_valid` ← ~`mux_en_n`.
- `sel` values 0..3 map to a, b, c, d.

## Timing
- Request to grant latency: `req` high before edge N in IDLE → `gnt`/`sel`/`mux_en_n` valid after edge N.
- Grant to data latency: 1 cycle. `out`/`out_valid` follow `gnt` by one edge, and `out` reflects the input value sampled at that edge.
- Owned tenure under contention: exactly MAX_HOLD cycles of `gnt` high, then 1 GAP cycle. Handover period is MAX_HOLD+1 cycles.
- Early drop: `req[owner]` low before edge N → `gnt` low after edge N; `out_valid` low after edge N+1.
- Simultaneous events:
  - Owner drops while hold expires: treated as a release, with a single GAP.
  - A new `req` arriving during GAP is eligible at the GAP-exit edge.
- Reset asserted mid-tenure: all outputs go to reset values immediately (asynchronous, no clock needed). After deassertion, the first arbitration starts from requester 0 priority.
- `gnt` is never multi-hot. `mux_en_n`=0 if and only if `gnt`≠0.

## Test plan
- Reset: hold `rst_n`=0 with `req`=4'b1111 → `gnt`=0, `mux_en_n`=1, `out`=0, `out_valid`=0. First grant after release of reset → `gnt`=4'b0001.
- Single requester: `req`=4'b0100, `c`=4'hA held 20 cycles → `gnt`=4'b0100 continuously, no GAP, `sel`=2. `out`=4'hA with `out_valid`=1 from the second cycle on.
- Contention: `req`=4'b0101, MAX_HOLD=8 → `gnt` 0001 for 8 cycles, 0 for 1 cycle, 0100 for 8 cycles, 0 for 1 cycle, then 0001 again.
- Rotation: `req`=4'b1111 → grant order 0,1,2,3,0. `out` tracks a, b, c, d, a respectively, each delayed one cycle.
- Early release: owner 1 drops `req[1]` after 3 cycles while `req[3]`=1 → `gnt` 0010 for 3 cycles, one zero cycle, then 1000.
- Async reset mid-grant: assert `rst_n`=0 between edges during owner 2 → outputs clear without a clock edge. After deassert with `req`=4'b0110 → `gnt`=4'b0010.
